// File: rtl/mantissa_adder_arbiter.sv
// Round-robin arbiter sharing one 24-bit mantissa adder among NUM_REQ requesters.
// ADD takes one adder pass; SUB takes two (a + ~b, then +1). Results are held until accepted.

module mantissa_adder (
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic        cin,
    output logic [23:0] sum,
    output logic        cout
);
    logic [24:0] full_s;

    assign full_s = {1'b0, a} + {1'b0, b} + {24'd0, cin};
    assign sum    = full_s[23:0];
    assign cout   = full_s[24];
endmodule

module mantissa_adder_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic                  in_clk,
    input  logic                  in_rst_n,
    input  logic [NUM_REQ-1:0]    in_req,
    input  logic [NUM_REQ-1:0]    in_op,
    input  logic [NUM_REQ*24-1:0] in_a,
    input  logic [NUM_REQ*24-1:0] in_b,
    output logic [NUM_REQ-1:0]    out_ack,
    output logic                  out_valid,
    input  logic                  in_ready,
    output logic [TAG_W-1:0]      out_tag,
    output logic [23:0]           out_result,
    output logic                  out_carry
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PASS1 = 2'd1,
        S_PASS2 = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [NUM_REQ-1:0] ACK_BASE = NUM_REQ'(1);

    state_t               state_r;
    state_t               next_state_s;
    logic [TAG_W-1:0]     last_r;
    logic [TAG_W-1:0]     scan_idx_s;
    logic [TAG_W-1:0]     grant_idx_s;
    logic                 grant_found_s;
    logic                 capture_s;
    logic [23:0]          cap_a_s;
    logic [23:0]          cap_b_s;
    logic [23:0]          a_r;
    logic [23:0]          b_r;
    logic                 op_r;
    logic [TAG_W-1:0]     tag_r;
    logic [23:0]          sum_r;
    logic                 c1_r;
    logic [23:0]          add_a_s;
    logic [23:0]          add_b_s;
    logic [23:0]          add_sum_s;
    logic                 add_cout_s;
    logic [NUM_REQ-1:0]   out_ack_r;
    logic                 out_valid_r;
    logic [TAG_W-1:0]     out_tag_r;
    logic [23:0]          out_result_r;
    logic                 out_carry_r;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        scan_idx_s    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx_s    = TAG_W'((int'(last_r) + k) % NUM_REQ);
            grant_idx_s   = (in_req[scan_idx_s] && !grant_found_s) ? scan_idx_s : grant_idx_s;
            grant_found_s = grant_found_s | in_req[scan_idx_s];
        end
    end

    assign capture_s = (state_r == S_IDLE) && grant_found_s;
    assign cap_a_s   = in_a[int'(grant_idx_s)*24 +: 24];
    assign cap_b_s   = in_b[int'(grant_idx_s)*24 +: 24];

    // Operand mux for the single shared adder: second SUB pass adds the +1.
    always_comb begin
        add_a_s = a_r;
        add_b_s = op_r ? ~b_r : b_r;
        case (state_r)
            S_PASS2: begin
                add_a_s = sum_r;
                add_b_s = 24'd1;
            end
            default: begin
                add_a_s = a_r;
                add_b_s = op_r ? ~b_r : b_r;
            end
        endcase
    end

    mantissa_adder u_adder (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (1'b0),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (grant_found_s) begin
                    next_state_s = S_PASS1;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_PASS1: begin
                if (op_r) begin
                    next_state_s = S_PASS2;
                end else begin
                    next_state_s = S_RESP;
                end
            end
            S_PASS2: next_state_s = S_RESP;
            S_RESP: begin
                if (in_ready) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_RESP;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture of the granted requester's operands; inputs are not looked at again.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            last_r <= TAG_W'(NUM_REQ - 1);
            a_r    <= 24'd0;
            b_r    <= 24'd0;
            op_r   <= 1'b0;
            tag_r  <= '0;
        end else if (capture_s) begin
            last_r <= grant_idx_s;
            a_r    <= cap_a_s;
            b_r    <= cap_b_s;
            op_r   <= in_op[grant_idx_s];
            tag_r  <= grant_idx_s;
        end
    end

    // Datapath results and registered outputs.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            sum_r        <= 24'd0;
            c1_r         <= 1'b0;
            out_ack_r    <= '0;
            out_valid_r  <= 1'b0;
            out_tag_r    <= '0;
            out_result_r <= 24'd0;
            out_carry_r  <= 1'b0;
        end else begin
            out_ack_r <= capture_s ? (ACK_BASE << grant_idx_s) : '0;
            case (state_r)
                S_PASS1: begin
                    sum_r <= add_sum_s;
                    c1_r  <= add_cout_s;
                    if (!op_r) begin
                        out_valid_r  <= 1'b1;
                        out_tag_r    <= tag_r;
                        out_result_r <= add_sum_s;
                        out_carry_r  <= add_cout_s;
                    end
                end
                S_PASS2: begin
                    out_valid_r  <= 1'b1;
                    out_tag_r    <= tag_r;
                    out_result_r <= add_sum_s;
                    out_carry_r  <= c1_r | add_cout_s;
                end
                S_RESP: begin
                    if (in_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= out_valid_r;
                end
            endcase
        end
    end

    assign out_ack    = out_ack_r;
    assign out_valid  = out_valid_r;
    assign out_tag    = out_tag_r;
    assign out_result = out_result_r;
    assign out_carry  = out_carry_r;
endmodule

// File: tb/tb_mantissa_adder_arbiter.sv
// Scoreboard bench: directed transactions push expected {tag,result,carry}; a monitor pops on out_valid.

module tb_mantissa_adder_arbiter;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    op = '0;
    logic [N*24-1:0] a = '0;
    logic [N*24-1:0] b = '0;
    logic            ready = 1'b1;
    logic [N-1:0]    ack;
    logic            valid;
    logic [1:0]      tag;
    logic [23:0]     result;
    logic            carry;

    int          checks = 0;
    int          errors = 0;
    logic [26:0] exp_q[$];

    always #5 clk = ~clk;

    mantissa_adder_arbiter #(.NUM_REQ(N)) dut (
        .in_clk     (clk),
        .in_rst_n   (rst_n),
        .in_req     (req),
        .in_op      (op),
        .in_a       (a),
        .in_b       (b),
        .out_ack    (ack),
        .out_valid  (valid),
        .in_ready   (ready),
        .out_tag    (tag),
        .out_result (result),
        .out_carry  (carry)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, expv);
        end
    endtask

    // Monitor: first valid cycle pops and compares; later cycles until handshake check stability.
    logic        seen = 1'b0;
    logic [26:0] held = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (valid) begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {5'd0, tag, result, carry}, 32'hFFFF_FFFF);
                    held = {tag, result, carry};
                end else begin
                    held = exp_q.pop_front();
                    chk("result", {5'd0, tag, result, carry}, {5'd0, held});
                end
                seen = 1'b1;
            end else begin
                chk("hold_stable", {5'd0, tag, result, carry}, {5'd0, held});
            end
            if (ready) seen = 1'b0;
        end
    end

    task automatic do_txn(input int idx, input logic sub, input logic [23:0] av, input logic [23:0] bv,
                          input logic [23:0] res, input logic cy);
        int n;
        @(posedge clk); #1;
        req[idx]          = 1'b1;
        op[idx]           = sub;
        a[idx*24 +: 24]   = av;
        b[idx*24 +: 24]   = bv;
        exp_q.push_back({2'(idx), res, cy});
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (ack == '0 && n < 10);
        chk("ack_latency", n, 1);
        chk("ack_onehot", {28'd0, ack}, 32'd1 << idx);
        req[idx] = 1'b0;
        while (!valid && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk("valid_latency", n, sub ? 32'd3 : 32'd2);
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid) && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int cnt;
        int n;
        #12;
        chk("rst_ack", {28'd0, ack}, 0);
        chk("rst_out", {5'd0, valid, tag, result, carry}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic ADD with carry-out, then SUB cases.
        do_txn(0, 1'b0, 24'h800000, 24'h800000, 24'h000000, 1'b1);
        do_txn(1, 1'b1, 24'h000005, 24'h000003, 24'h000002, 1'b1);
        do_txn(1, 1'b1, 24'h000003, 24'h000005, 24'hFFFFFE, 1'b0);
        do_txn(2, 1'b1, 24'h000007, 24'h000000, 24'h000007, 1'b1);
        do_txn(3, 1'b1, 24'h000000, 24'h000000, 24'h000000, 1'b1);
        wait_drain(10);

        // Round-robin fairness from reset with all requests high.
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            op[i]          = 1'b0;
            a[i*24 +: 24]  = 24'(i);
            b[i*24 +: 24]  = 24'd1;
        end
        for (int i = 0; i < N; i++) exp_q.push_back({2'(i), 24'(i + 1), 1'b0});
        exp_q.push_back({2'd0, 24'd1, 1'b0});
        req = '1;
        cnt = 0;
        for (int c = 0; c < 60 && cnt < 5; c++) begin
            @(posedge clk); #1;
            if (ack != '0) cnt++;
        end
        req = '0;
        chk("rr_acks", cnt, 5);
        wait_drain(20);

        // Backpressure: result held, pending req2 waits for handshake.
        ready = 1'b0;
        do_txn(1, 1'b0, 24'h123456, 24'h111111, 24'h234567, 1'b0);
        exp_q.push_back({2'd2, 24'h000030, 1'b0});
        op[2]          = 1'b0;
        a[2*24 +: 24]  = 24'h000010;
        b[2*24 +: 24]  = 24'h000020;
        req[2]         = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_no_ack", {28'd0, ack}, 0);
            chk("bp_valid", {31'd0, valid}, 1);
        end
        ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_valid_drop", {31'd0, valid}, 0);
        chk("hs_no_ack", {28'd0, ack}, 0);
        @(posedge clk); #1;
        chk("pending_ack", {28'd0, ack}, 32'h4);
        req[2] = 1'b0;
        wait_drain(10);

        // Reset during PASS2 of a SUB, then fresh service with priority from requester 0.
        @(posedge clk); #1;
        op[1]          = 1'b1;
        a[1*24 +: 24]  = 24'd9;
        b[1*24 +: 24]  = 24'd4;
        req[1]         = 1'b1;
        @(posedge clk); #1;
        chk("abort_ack", {28'd0, ack}, 32'h2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ack0", {28'd0, ack}, 0);
        chk("abort_out0", {5'd0, valid, tag, result, carry}, 0);
        op[3]          = 1'b0;
        a[3*24 +: 24]  = 24'h00FFFF;
        b[3*24 +: 24]  = 24'h000001;
        req[3]         = 1'b1;
        exp_q.push_back({2'd1, 24'd5, 1'b1});
        exp_q.push_back({2'd3, 24'h010000, 1'b0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ack", {28'd0, ack}, 32'h2);
        req[1] = 1'b0;
        n = 0;
        while (!ack[3] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req3_acked", {31'd0, ack[3]}, 1);
        req[3] = 1'b0;
        wait_drain(20);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
